ddram_arb: RTL and testbench

//  Parametrised N-channel front end for the 64-bit DDRAM (Avalon-MM) port; successor of the single-channel bridge.

---
 rtl/ddram_arb_pkg.sv | 35 +++
 rtl/ddram_rr_arb.sv | 56 +++++
 rtl/ddram_arb.sv | 185 ++++++++++++++++++
 tb/tb_ddram_arb.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddram_arb_pkg.sv
// Shared types, widths and helpers for the N-channel DDRAM arbiter.
// Optional build macro used by the arbiter files: DDRAM_ARB_CH0_PRIO_EN.
package ddram_arb_pkg;

    localparam int ADDR_W = 25;
    localparam int DATA_W = 64;
    localparam int BE_W   = 8;
    localparam int LEN_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RD_DATA
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [DATA_W-1:0] din;
        logic [BE_W-1:0]   be;
        logic              rnw;
    } req_t;

    // A zero length still moves one beat; anything above the burst limit is cut down to it.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len, input int max_burst);
        if (len == '0) begin
            return LEN_W'(1);
        end
        if (int'(len) > max_burst) begin
            return LEN_W'(max_burst);
        end
        return len;
    endfunction

endpackage

// File: rtl/ddram_rr_arb.sv
// Combinational round-robin picker: pending mask + pointer -> one-hot grant and index.
// With DDRAM_ARB_CH0_PRIO_EN defined, channel 0 always wins and the rotation covers the rest.
module ddram_rr_arb
    import ddram_arb_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int IDX_W = 1
) (
    input  logic [NCH-1:0]   pending,
    input  logic [IDX_W-1:0] ptr,
    output logic [NCH-1:0]   grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             valid
);

    logic [NCH-1:0]   rr_mask;
    logic             found_hi;
    logic             found_lo;
    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] lo_idx;

    // Two ascending scans: first candidate at/after the pointer, else the first one overall (wrap).
    always_comb begin
        rr_mask = pending;
`ifdef DDRAM_ARB_CH0_PRIO_EN
        rr_mask[0] = 1'b0;
`endif
        found_hi = 1'b0;
        found_lo = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (rr_mask[i] && !found_hi && (i >= int'(ptr))) begin
                found_hi = 1'b1;
                hi_idx   = IDX_W'(i);
            end
            if (rr_mask[i] && !found_lo) begin
                found_lo = 1'b1;
                lo_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        valid     = found_hi || found_lo;
        grant_idx = found_hi ? hi_idx : lo_idx;
`ifdef DDRAM_ARB_CH0_PRIO_EN
        if (pending[0]) begin
            valid     = 1'b1;
            grant_idx = '0;
        end
`endif
        grant = valid ? (NCH'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/ddram_arb.sv
// N-channel front end for the 64-bit Avalon-MM DDRAM port: request slots, arbitration, burst issue.
// Build option: DDRAM_ARB_CH0_PRIO_EN gives channel 0 absolute priority over the round-robin.
module ddram_arb
    import ddram_arb_pkg::*;
#(
    parameter int         NCH       = 2,
    parameter int         MAX_BURST = 8,
    parameter logic [3:0] BASE      = 4'b0011
) (
    input  logic                  DDRAM_CLK,
    input  logic                  RESET_N,
    input  logic                  DDRAM_BUSY,
    output logic [LEN_W-1:0]      DDRAM_BURSTCNT,
    output logic [28:0]           DDRAM_ADDR,
    input  logic [DATA_W-1:0]     DDRAM_DOUT,
    input  logic                  DDRAM_DOUT_READY,
    output logic                  DDRAM_RD,
    output logic [DATA_W-1:0]     DDRAM_DIN,
    output logic [BE_W-1:0]       DDRAM_BE,
    output logic                  DDRAM_WE,
    input  logic [NCH*ADDR_W-1:0] ch_addr,
    input  logic [NCH*LEN_W-1:0]  ch_len,
    input  logic [NCH*DATA_W-1:0] ch_din,
    input  logic [NCH*BE_W-1:0]   ch_be,
    input  logic [NCH-1:0]        ch_rnw,
    input  logic [NCH-1:0]        ch_req,
    output logic [NCH-1:0]        ch_busy,
    output logic [DATA_W-1:0]     ch_dout,
    output logic [NCH-1:0]        ch_rvalid,
    output logic [NCH-1:0]        ch_done
);

    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

    state_t           state_q;
    state_t           state_d;
    req_t             slot_q [NCH];
    req_t             gslot;
    logic [NCH-1:0]   busy_q;
    logic [NCH-1:0]   gnt_oh_q;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] next_ptr;
    logic [LEN_W-1:0] cnt_q;

    logic [NCH-1:0]   grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_valid;

    logic             grant_fire;
    logic             cmd_accept;
    logic             beat;
    logic             last_beat;
    logic [NCH-1:0]   clear_mask;

    assign ch_busy = busy_q;
    assign gslot   = slot_q[grant_idx];

    ddram_rr_arb #(
        .NCH   (NCH),
        .IDX_W (IDX_W)
    ) u_rr_arb (
        .pending   (busy_q),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .valid     (grant_valid)
    );

    always_ff @(posedge DDRAM_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_fire) state_d = ISSUE;
            ISSUE:   if (cmd_accept) state_d = DDRAM_RD ? RD_DATA : IDLE;
            RD_DATA: if (last_beat)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_fire = 1'b0;
        cmd_accept = 1'b0;
        beat       = 1'b0;
        last_beat  = 1'b0;
        case (state_q)
            IDLE:    grant_fire = grant_valid;
            ISSUE:   cmd_accept = !DDRAM_BUSY;
            RD_DATA: begin
                beat      = DDRAM_DOUT_READY;
                last_beat = DDRAM_DOUT_READY && (cnt_q == LEN_W'(1));
            end
            default: ;
        endcase
        clear_mask = ((cmd_accept && DDRAM_WE) || last_beat) ? gnt_oh_q : '0;
    end

    // A channel granted by priority leaves the rotation where it was.
    always_comb begin
        next_ptr = ptr_q;
`ifdef DDRAM_ARB_CH0_PRIO_EN
        if (grant_idx != '0) begin
            next_ptr = (int'(grant_idx) == NCH - 1) ? IDX_W'(1) : grant_idx + 1'b1;
        end
`else
        next_ptr = (int'(grant_idx) == NCH - 1) ? '0 : grant_idx + 1'b1;
`endif
    end

    // A strobe on an occupied slot is dropped so the first request is served intact.
    always_ff @(posedge DDRAM_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            busy_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (ch_req[i] && !busy_q[i]) begin
                    slot_q[i] <= '{addr: ch_addr[i*ADDR_W +: ADDR_W],
                                   len:  clamp_len(ch_len[i*LEN_W +: LEN_W], MAX_BURST),
                                   din:  ch_din[i*DATA_W +: DATA_W],
                                   be:   ch_be[i*BE_W +: BE_W],
                                   rnw:  ch_rnw[i]};
                    busy_q[i] <= 1'b1;
                end else if (clear_mask[i]) begin
                    busy_q[i] <= 1'b0;
                end
            end
        end
    end

    // Command registers stay frozen while the memory stalls, which keeps them Avalon-legal.
    always_ff @(posedge DDRAM_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            DDRAM_RD       <= 1'b0;
            DDRAM_WE       <= 1'b0;
            DDRAM_ADDR     <= '0;
            DDRAM_BURSTCNT <= '0;
            DDRAM_DIN      <= '0;
            DDRAM_BE       <= '0;
            gnt_oh_q       <= '0;
            ptr_q          <= '0;
            cnt_q          <= '0;
        end else if (grant_fire) begin
            DDRAM_RD       <= gslot.rnw;
            DDRAM_WE       <= !gslot.rnw;
            DDRAM_ADDR     <= {BASE, gslot.addr};
            DDRAM_BURSTCNT <= gslot.rnw ? gslot.len : LEN_W'(1);
            DDRAM_DIN      <= gslot.din;
            DDRAM_BE       <= gslot.rnw ? {BE_W{1'b1}} : gslot.be;
            gnt_oh_q       <= grant;
            ptr_q          <= next_ptr;
        end else if (cmd_accept) begin
            DDRAM_RD <= 1'b0;
            DDRAM_WE <= 1'b0;
            if (DDRAM_RD) begin
                cnt_q <= DDRAM_BURSTCNT;
            end
        end else if (beat) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge DDRAM_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ch_dout   <= '0;
            ch_rvalid <= '0;
            ch_done   <= '0;
        end else begin
            ch_rvalid <= beat ? gnt_oh_q : '0;
            ch_done   <= clear_mask;
            if (beat) begin
                ch_dout <= DDRAM_DOUT;
            end
        end
    end

endmodule

// File: tb/tb_ddram_arb.sv
// Randomised and directed bench for ddram_arb against a transaction-level reference model.
// Honours DDRAM_ARB_CH0_PRIO_EN in the reference arbitration rule.
module tb_ddram_arb;

    localparam int         NCH  = 2;
    localparam int         MAXB = 8;
    localparam logic [3:0] BASE = 4'b0011;

    logic              DDRAM_CLK = 1'b0;
    logic              RESET_N = 1'b0;
    logic              DDRAM_BUSY = 1'b0;
    logic              DDRAM_DOUT_READY = 1'b0;
    logic [63:0]       DDRAM_DOUT = '0;
    logic [7:0]        DDRAM_BURSTCNT;
    logic [28:0]       DDRAM_ADDR;
    logic              DDRAM_RD;
    logic [63:0]       DDRAM_DIN;
    logic [7:0]        DDRAM_BE;
    logic              DDRAM_WE;
    logic [NCH*25-1:0] ch_addr = '0;
    logic [NCH*8-1:0]  ch_len = '0;
    logic [NCH*64-1:0] ch_din = '0;
    logic [NCH*8-1:0]  ch_be = '0;
    logic [NCH-1:0]    ch_rnw = '0;
    logic [NCH-1:0]    ch_req = '0;
    logic [NCH-1:0]    ch_busy;
    logic [63:0]       ch_dout;
    logic [NCH-1:0]    ch_rvalid;
    logic [NCH-1:0]    ch_done;

    int total = 0;
    int bad = 0;

    // Reference model: slots, pending set, bus owner and expected outputs after each edge.
    logic [NCH-1:0] m_busy;
    int             m_ptr;
    int             owner;
    bit             in_data;
    int             remaining;
    logic [24:0]    m_addr [NCH];
    int             m_len  [NCH];
    logic [63:0]    m_din  [NCH];
    logic [7:0]     m_be   [NCH];
    logic           m_rnw  [NCH];
    logic           e_rd, e_we;
    logic [28:0]    e_addr;
    logic [7:0]     e_bc, e_be;
    logic [63:0]    e_din, e_dout;
    logic [NCH-1:0] e_rvalid, e_done;

    ddram_arb #(.NCH(NCH), .MAX_BURST(MAXB), .BASE(BASE)) dut (
        .DDRAM_CLK(DDRAM_CLK), .RESET_N(RESET_N), .DDRAM_BUSY(DDRAM_BUSY),
        .DDRAM_BURSTCNT(DDRAM_BURSTCNT), .DDRAM_ADDR(DDRAM_ADDR), .DDRAM_DOUT(DDRAM_DOUT),
        .DDRAM_DOUT_READY(DDRAM_DOUT_READY), .DDRAM_RD(DDRAM_RD), .DDRAM_DIN(DDRAM_DIN),
        .DDRAM_BE(DDRAM_BE), .DDRAM_WE(DDRAM_WE), .ch_addr(ch_addr), .ch_len(ch_len),
        .ch_din(ch_din), .ch_be(ch_be), .ch_rnw(ch_rnw), .ch_req(ch_req), .ch_busy(ch_busy),
        .ch_dout(ch_dout), .ch_rvalid(ch_rvalid), .ch_done(ch_done)
    );

    always #5 DDRAM_CLK = ~DDRAM_CLK;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Closest pending channel at or after the pointer, measured as a wrapped distance.
    function automatic int rrPick(input logic [NCH-1:0] pend, input int ptr);
        int best = -1;
        int bestd = NCH + 1;
        int start = ptr;
        int lo = 0;
`ifdef DDRAM_ARB_CH0_PRIO_EN
        if (pend[0]) return 0;
        lo = 1;
        if (start == 0) start = 1;
`endif
        for (int i = lo; i < NCH; i++) begin
            if (pend[i]) begin
                int d = (i - start + NCH) % NCH;
                if (d < bestd) begin
                    bestd = d;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    task automatic modelReset();
        m_busy = '0; m_ptr = 0; owner = -1; in_data = 0; remaining = 0;
        e_rd = 0; e_we = 0; e_addr = '0; e_bc = '0; e_be = '0; e_din = '0; e_dout = '0;
        e_rvalid = '0; e_done = '0;
    endtask

    task automatic modelStep();
        logic [NCH-1:0] pre_busy = m_busy;
        e_rvalid = '0;
        e_done = '0;
        if (owner < 0) begin
            if (pre_busy != '0) begin
                int p = rrPick(pre_busy, m_ptr);
                owner = p;
                in_data = 0;
                e_rd = m_rnw[p];
                e_we = !m_rnw[p];
                e_addr = {BASE, m_addr[p]};
                e_bc = m_rnw[p] ? 8'(m_len[p]) : 8'd1;
                e_din = m_din[p];
                e_be = m_rnw[p] ? 8'hFF : m_be[p];
`ifdef DDRAM_ARB_CH0_PRIO_EN
                if (p != 0) m_ptr = (p + 1 == NCH) ? 1 : p + 1;
`else
                m_ptr = (p + 1) % NCH;
`endif
            end
        end else if (!in_data) begin
            if (!DDRAM_BUSY) begin
                e_rd = 0;
                e_we = 0;
                if (m_rnw[owner]) begin
                    in_data = 1;
                    remaining = m_len[owner];
                end else begin
                    e_done[owner] = 1'b1;
                    m_busy[owner] = 1'b0;
                    owner = -1;
                end
            end
        end else if (DDRAM_DOUT_READY) begin
            e_rvalid[owner] = 1'b1;
            e_dout = DDRAM_DOUT;
            remaining--;
            if (remaining == 0) begin
                e_done[owner] = 1'b1;
                m_busy[owner] = 1'b0;
                owner = -1;
            end
        end
        for (int i = 0; i < NCH; i++) begin
            if (ch_req[i] && !pre_busy[i]) begin
                int l = int'(ch_len[i*8 +: 8]);
                m_addr[i] = ch_addr[i*25 +: 25];
                m_len[i] = (l == 0) ? 1 : ((l > MAXB) ? MAXB : l);
                m_din[i] = ch_din[i*64 +: 64];
                m_be[i] = ch_be[i*8 +: 8];
                m_rnw[i] = ch_rnw[i];
                m_busy[i] = 1'b1;
            end
        end
    endtask

    task automatic compareCycle();
        checkOutput("rd", DDRAM_RD, e_rd);
        checkOutput("we", DDRAM_WE, e_we);
        checkOutput("busy", ch_busy, m_busy);
        checkOutput("rvalid", ch_rvalid, e_rvalid);
        checkOutput("done", ch_done, e_done);
        if (e_rd || e_we) begin
            checkOutput("addr", DDRAM_ADDR, e_addr);
            checkOutput("burstcnt", DDRAM_BURSTCNT, e_bc);
            checkOutput("be", DDRAM_BE, e_be);
        end
        if (e_we) checkOutput("din", DDRAM_DIN, e_din);
        if (e_rvalid != '0) checkOutput("dout", ch_dout, e_dout);
    endtask

    // Drive one cycle of inputs, clock it, then advance the model and compare.
    task automatic applyStimulus(input logic [NCH-1:0] req, input logic busy, input logic dready);
        ch_req = req;
        DDRAM_BUSY = busy;
        DDRAM_DOUT_READY = dready;
        DDRAM_DOUT = {$urandom, $urandom};
        @(posedge DDRAM_CLK);
        #1;
        modelStep();
        compareCycle();
        ch_req = '0;
    endtask

    task automatic setChannel(input int ch, input logic rnw, input logic [24:0] addr,
                              input logic [7:0] len, input logic [63:0] din, input logic [7:0] be);
        ch_rnw[ch] = rnw;
        ch_addr[ch*25 +: 25] = addr;
        ch_len[ch*8 +: 8] = len;
        ch_din[ch*64 +: 64] = din;
        ch_be[ch*8 +: 8] = be;
    endtask

    task automatic randomChannel(input int ch);
        int r = $urandom_range(0, 9);
        logic [7:0] len = (r == 0) ? 8'd0 : ((r == 9) ? 8'($urandom_range(9, 255)) : 8'(r));
        setChannel(ch, 1'($urandom_range(0, 1)), 25'($urandom), len, {$urandom, $urandom}, 8'($urandom));
    endtask

    task automatic runUntilIdle(output logic [NCH-1:0] first_done);
        first_done = '0;
        for (int n = 0; n < 400 && (owner >= 0 || m_busy != '0); n++) begin
            applyStimulus('0, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
            if (first_done == '0) first_done = ch_done;
        end
        if (owner >= 0 || m_busy != '0) checkOutput("drain_timeout", 64'd1, 64'd0);
    endtask

    task automatic doReset();
        RESET_N = 1'b0;
        ch_req = '0;
        DDRAM_BUSY = 1'b0;
        DDRAM_DOUT_READY = 1'b0;
        #2;
        checkOutput("rst_cmd", {DDRAM_RD, DDRAM_WE, DDRAM_BURSTCNT, DDRAM_BE}, 64'd0);
        checkOutput("rst_addr", DDRAM_ADDR, 64'd0);
        checkOutput("rst_din", DDRAM_DIN, 64'd0);
        checkOutput("rst_ch", {ch_busy, ch_rvalid, ch_done}, 64'd0);
        checkOutput("rst_dout", ch_dout, 64'd0);
        modelReset();
        @(posedge DDRAM_CLK);
        #1;
        checkOutput("rst_no_done", ch_done, 64'd0);
        RESET_N = 1'b1;
    endtask

    initial begin
        logic [NCH-1:0] fd;
        logic [NCH-1:0] rq;
        int nvalid;
        int ndone;
        modelReset();
        doReset();

        $display("[TB] single masked write on channel 0");
        setChannel(0, 1'b0, 25'h10, 8'd1, 64'h1122334455667788, 8'h0F);
        applyStimulus(2'b01, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b0, 1'b0);
        checkOutput("t1_we", DDRAM_WE, 64'd1);
        checkOutput("t1_addr", DDRAM_ADDR, 64'h06000010);
        checkOutput("t1_be", DDRAM_BE, 64'h0F);
        checkOutput("t1_bc", DDRAM_BURSTCNT, 64'd1);
        applyStimulus(2'b00, 1'b0, 1'b0);
        checkOutput("t1_done", ch_done, 64'b01);
        checkOutput("t1_we_drop", DDRAM_WE, 64'd0);

        $display("[TB] four-beat read on channel 1 with gaps");
        setChannel(1, 1'b1, 25'h1234, 8'd4, '0, '0);
        applyStimulus(2'b10, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b0, 1'b0);
        checkOutput("t2_bc", DDRAM_BURSTCNT, 64'd4);
        nvalid = 0;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            applyStimulus(2'b00, 1'b0, (k % 2 == 0));
            if (ch_rvalid[1]) nvalid++;
            if (ch_done[1]) ndone++;
        end
        checkOutput("t2_beats", 64'(nvalid), 64'd4);
        checkOutput("t2_dones", 64'(ndone), 64'd1);

        $display("[TB] simultaneous strobes, pointer wrap");
        for (int rep = 0; rep < 2; rep++) begin
            setChannel(0, 1'b1, 25'h100, 8'd1, '0, '0);
            setChannel(1, 1'b1, 25'h200, 8'd1, '0, '0);
            applyStimulus(2'b11, 1'b0, 1'b0);
            runUntilIdle(fd);
            checkOutput("t3_first", fd, 64'b01);
        end

        $display("[TB] stalled read command");
        setChannel(1, 1'b1, 25'h0ABCDE, 8'd3, '0, '0);
        applyStimulus(2'b10, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(2'b00, 1'b1, 1'b0);
            checkOutput("t4_rd_hold", DDRAM_RD, 64'd1);
        end
        applyStimulus(2'b00, 1'b0, 1'b0);
        checkOutput("t4_rd_drop", DDRAM_RD, 64'd0);
        runUntilIdle(fd);

        $display("[TB] length clamping");
        setChannel(0, 1'b1, 25'h55, 8'd0, '0, '0);
        applyStimulus(2'b01, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b0, 1'b0);
        checkOutput("t6_len0", DDRAM_BURSTCNT, 64'd1);
        runUntilIdle(fd);
        setChannel(1, 1'b1, 25'h66, 8'd200, '0, '0);
        applyStimulus(2'b10, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b0, 1'b0);
        checkOutput("t6_len200", DDRAM_BURSTCNT, 64'd8);
        runUntilIdle(fd);

        $display("[TB] channel 0 served alone, then both strobe");
        for (int rep = 0; rep < 2; rep++) begin
            setChannel(0, 1'b0, 25'h300, 8'd1, 64'hA5, 8'h01);
            applyStimulus(2'b01, 1'b0, 1'b0);
            runUntilIdle(fd);
            setChannel(1, 1'b0, 25'h400, 8'd1, 64'h5A, 8'h80);
            applyStimulus(2'b11, 1'b0, 1'b0);
            runUntilIdle(fd);
`ifdef DDRAM_ARB_CH0_PRIO_EN
            checkOutput("t7_prio_first", fd, 64'b01);
`else
            checkOutput("t7_rr_first", fd, 64'b10);
`endif
        end

        $display("[TB] reset in the middle of a burst");
        setChannel(0, 1'b1, 25'h777, 8'd4, '0, '0);
        applyStimulus(2'b01, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b0, 1'b1);
        applyStimulus(2'b00, 1'b0, 1'b1);
        doReset();
        setChannel(1, 1'b0, 25'h888, 8'd1, 64'hDEAD, 8'hF0);
        applyStimulus(2'b10, 1'b0, 1'b0);
        runUntilIdle(fd);
        checkOutput("t5_after_reset", fd, 64'b10);

        $display("[TB] random traffic");
        for (int n = 0; n < 2000; n++) begin
            if (n == 1000) doReset();
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 3) == 0) randomChannel(c);
                rq[c] = ($urandom_range(0, 3) == 0);
            end
            applyStimulus(rq, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0));
        end
        runUntilIdle(fd);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
